// File: rtl/sound_voice_mixer_if.sv
// Shared SRAM sample read port: the voice mixer drives requests (master), the sample memory answers (slave).
interface sound_voice_mixer_if #(
    parameter int ADDR_W   = 20,
    parameter int SAMPLE_W = 16
) ();
    logic                o_rd_req;
    logic [ADDR_W-1:0]   o_rd_addr;
    logic                i_rd_ack;
    logic [SAMPLE_W-1:0] i_rd_data;

    modport master (
        output o_rd_req,
        output o_rd_addr,
        input  i_rd_ack,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_req,
        input  o_rd_addr,
        output i_rd_ack,
        output i_rd_data
    );
endinterface

// File: rtl/sound_voice_mixer.sv
// Programmable sound table plus N_VOICES concurrent sample players mixed with saturation once per sample tick.
// Optional looping playback is enabled by defining SOUND_VOICE_LOOP_EN.
module sound_voice_mixer #(
    parameter int N_SOUNDS = 25,
    parameter int N_VOICES = 4,
    parameter int ADDR_W   = 20,
    parameter int SAMPLE_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tbl_we,
    input  logic [$clog2(N_SOUNDS)-1:0] i_tbl_idx,
    input  logic [ADDR_W-1:0]           i_tbl_addr,
    input  logic [ADDR_W-1:0]           i_tbl_len,
    input  logic                        i_trig,
    input  logic [$clog2(N_SOUNDS)-1:0] i_trig_id,
    input  logic                        i_trig_loop,
    input  logic                        i_stop_all,
    output logic                        o_trig_ready,
    output logic                        o_trig_drop,
    input  logic                        i_sample_tick,
    sound_voice_mixer_if.master         rd_if,
    output logic [SAMPLE_W-1:0]         o_sample,
    output logic                        o_sample_valid,
    output logic [N_VOICES-1:0]         o_active,
    output logic                        o_overrun
);

    localparam int VW    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + VW;
    localparam logic [VW-1:0] LAST_V = VW'(N_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MIX   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   tbl_addr_q [N_SOUNDS];
    logic [ADDR_W-1:0]   tbl_len_q  [N_SOUNDS];

    logic [N_VOICES-1:0] v_act_q, v_act_d;
    logic [N_VOICES-1:0] v_loop_q, v_loop_d;
    logic [ADDR_W-1:0]   v_base_q [N_VOICES];
    logic [ADDR_W-1:0]   v_base_d [N_VOICES];
    logic [ADDR_W-1:0]   v_len_q  [N_VOICES];
    logic [ADDR_W-1:0]   v_len_d  [N_VOICES];
    logic [ADDR_W-1:0]   v_pos_q  [N_VOICES];
    logic [ADDR_W-1:0]   v_pos_d  [N_VOICES];

    logic [VW-1:0]       cur_q, cur_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [N_VOICES-1:0] active_q, active_d;
    logic                overrun_q, overrun_d;
    logic                drop_q, drop_d;

    logic                id_ok_s;
    logic                wr_ok_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [ADDR_W-1:0]   sel_len_s;
    logic [VW:0]         free_s;
    logic [VW-1:0]       free_idx_s;
    logic                adv_s;

    // Lowest-index idle voice; MSB flags that one exists.
    function automatic logic [VW:0] find_free(input logic [N_VOICES-1:0] act);
        logic [VW:0] r;
        r = '0;
        for (int k = N_VOICES - 1; k >= 0; k--) begin
            if (!act[k]) begin
                r = {1'b1, VW'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] d);
        return {{VW{d[SAMPLE_W-1]}}, d};
    endfunction

    // Clamp when the guard bits above the sample sign bit disagree.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] a);
        logic [VW:0] hi;
        hi = a[ACC_W-1:SAMPLE_W-1];
        if ((&hi) || (~|hi)) begin
            return a[SAMPLE_W-1:0];
        end else if (a[ACC_W-1]) begin
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    endfunction

`ifndef SOUND_VOICE_LOOP_EN
    logic unused_trig_loop_s;
    assign unused_trig_loop_s = i_trig_loop;
`endif

    assign id_ok_s    = (int'(i_trig_id) < N_SOUNDS);
    assign wr_ok_s    = (int'(i_tbl_idx) < N_SOUNDS);
    assign sel_addr_s = id_ok_s ? tbl_addr_q[i_trig_id] : {ADDR_W{1'b0}};
    assign sel_len_s  = id_ok_s ? tbl_len_q[i_trig_id]  : {ADDR_W{1'b0}};
    assign free_s     = find_free(v_act_q);
    assign free_idx_s = free_s[VW-1:0];

    assign o_trig_ready    = (state_q == ST_IDLE);
    assign o_trig_drop     = drop_q;
    assign rd_if.o_rd_req  = req_q;
    assign rd_if.o_rd_addr = addr_q;
    assign o_sample        = sample_q;
    assign o_sample_valid  = valid_q;
    assign o_active        = active_q;
    assign o_overrun       = overrun_q;

    // Sound table write port; new entries are visible from the next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tbl_addr_q <= '{default: '0};
            tbl_len_q  <= '{default: '0};
        end else if (i_tbl_we && wr_ok_s) begin
            tbl_addr_q[i_tbl_idx] <= i_tbl_addr;
            tbl_len_q[i_tbl_idx]  <= i_tbl_len;
        end
    end

    // Next-state logic for the sequencer, voice registers and outputs.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        acc_d     = acc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        drop_d    = 1'b0;
        overrun_d = overrun_q;
        active_d  = v_act_q;
        v_act_d   = v_act_q;
        v_loop_d  = v_loop_q;
        v_base_d  = v_base_q;
        v_len_d   = v_len_q;
        v_pos_d   = v_pos_q;
        adv_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_trig) begin
                    if (free_s[VW] && (sel_len_s != {ADDR_W{1'b0}})) begin
                        v_act_d[free_idx_s]  = 1'b1;
                        v_base_d[free_idx_s] = sel_addr_s;
                        v_len_d[free_idx_s]  = sel_len_s;
                        v_pos_d[free_idx_s]  = {ADDR_W{1'b0}};
`ifdef SOUND_VOICE_LOOP_EN
                        v_loop_d[free_idx_s] = i_trig_loop;
`else
                        v_loop_d[free_idx_s] = 1'b0;
`endif
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    drop_d = 1'b0;
                end
                if (i_sample_tick) begin
                    acc_d   = {ACC_W{1'b0}};
                    cur_d   = {VW{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (i_sample_tick) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                // An outstanding read always completes; its data only counts if the voice survived.
                if (req_q) begin
                    if (rd_if.i_rd_ack) begin
                        req_d = 1'b0;
                        adv_s = 1'b1;
                        if (v_act_q[cur_q] && !i_stop_all) begin
                            acc_d = acc_q + sext(rd_if.i_rd_data);
                            if (v_pos_q[cur_q] == (v_len_q[cur_q] - ADDR_W'(1))) begin
                                v_pos_d[cur_q] = {ADDR_W{1'b0}};
                                v_act_d[cur_q] = v_loop_q[cur_q];
                            end else begin
                                v_pos_d[cur_q] = v_pos_q[cur_q] + ADDR_W'(1);
                            end
                        end else begin
                            acc_d = acc_q;
                        end
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (v_act_q[cur_q] && !i_stop_all) begin
                    req_d  = 1'b1;
                    addr_d = v_base_q[cur_q] + v_pos_q[cur_q];
                end else begin
                    adv_s = 1'b1;
                end
                if (adv_s) begin
                    if (cur_q == LAST_V) begin
                        state_d = ST_MIX;
                    end else begin
                        cur_d = cur_q + VW'(1);
                    end
                end else begin
                    cur_d = cur_q;
                end
            end

            ST_MIX: begin
                if (i_sample_tick) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                sample_d = saturate(acc_q);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (i_stop_all) begin
            v_act_d = {N_VOICES{1'b0}};
        end else begin
            v_act_d = v_act_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= {VW{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            req_q     <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            sample_q  <= {SAMPLE_W{1'b0}};
            valid_q   <= 1'b0;
            active_q  <= {N_VOICES{1'b0}};
            overrun_q <= 1'b0;
            drop_q    <= 1'b0;
            v_act_q   <= {N_VOICES{1'b0}};
            v_loop_q  <= {N_VOICES{1'b0}};
            v_base_q  <= '{default: '0};
            v_len_q   <= '{default: '0};
            v_pos_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            acc_q     <= acc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            v_act_q   <= v_act_d;
            v_loop_q  <= v_loop_d;
            v_base_q  <= v_base_d;
            v_len_q   <= v_len_d;
            v_pos_q   <= v_pos_d;
        end
    end

endmodule

// File: tb/tb_sound_voice_mixer.sv
// Scoreboard bench for sound_voice_mixer: a transaction-level voice model predicts read addresses and mixed samples.
module tb_sound_voice_mixer;
    localparam int N_SOUNDS = 25;
    localparam int N_VOICES = 4;
    localparam int ADDR_W   = 20;
    localparam int SAMPLE_W = 16;
    localparam int AMASK    = 32'h000F_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tbl_we;
    logic [4:0]  tbl_idx;
    logic [19:0] tbl_addr;
    logic [19:0] tbl_len;
    logic        trig;
    logic [4:0]  trig_id;
    logic        trig_loop;
    logic        stop_all;
    logic        trig_ready;
    logic        trig_drop;
    logic        sample_tick;
    logic [15:0] sample;
    logic        sample_valid;
    logic [3:0]  active;
    logic        overrun;

    sound_voice_mixer_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) rd_if ();

    sound_voice_mixer #(
        .N_SOUNDS(N_SOUNDS), .N_VOICES(N_VOICES), .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_tbl_we(tbl_we), .i_tbl_idx(tbl_idx), .i_tbl_addr(tbl_addr), .i_tbl_len(tbl_len),
        .i_trig(trig), .i_trig_id(trig_id), .i_trig_loop(trig_loop), .i_stop_all(stop_all),
        .o_trig_ready(trig_ready), .o_trig_drop(trig_drop), .i_sample_tick(sample_tick),
        .rd_if(rd_if),
        .o_sample(sample), .o_sample_valid(sample_valid), .o_active(active), .o_overrun(overrun)
    );

    typedef struct {
        bit act;
        int base;
        int len;
        int pos;
        bit loop;
    } voice_t;

    int          m_tbl_addr [N_SOUNDS];
    int          m_tbl_len  [N_SOUNDS];
    voice_t      m_v        [N_VOICES];
    logic [15:0] mem        [int];
    int          exp_samples[$];
    int          exp_addrs  [$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          ack_delay = 0;
    int          ack_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int sram_val(input int a);
        if (mem.exists(a)) return int'(mem[a]);
        return ((a * 37) ^ 32'h1234) & 32'hFFFF;
    endfunction

    function automatic int s16(input int v);
        int x;
        x = v & 32'hFFFF;
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // One sample period. stop_after >= 0: voices are cleared while the read of the
    // stop_after-th active voice is outstanding; only the earlier voices count.
    function automatic void model_tick(input int stop_after);
        int sum;
        int n;
        int a;
        sum = 0;
        n   = 0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (m_v[v].act) begin
                a = (m_v[v].base + m_v[v].pos) & AMASK;
                exp_addrs.push_back(a);
                if (stop_after >= 0 && n == stop_after) break;
                sum += s16(sram_val(a));
                n++;
                if (m_v[v].pos == m_v[v].len - 1) begin
                    m_v[v].pos = 0;
                    if (!m_v[v].loop) m_v[v].act = 1'b0;
                end else begin
                    m_v[v].pos++;
                end
            end
        end
        if (stop_after >= 0) begin
            for (int v = 0; v < N_VOICES; v++) m_v[v].act = 1'b0;
        end
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
        exp_samples.push_back(sum & 32'hFFFF);
    endfunction

    function automatic bit model_trig(input int id, input bit lp);
        int f;
        f = -1;
        for (int v = N_VOICES - 1; v >= 0; v--) if (!m_v[v].act) f = v;
        if (f < 0 || m_tbl_len[id] == 0) return 1'b1;
        m_v[f].act  = 1'b1;
        m_v[f].base = m_tbl_addr[id];
        m_v[f].len  = m_tbl_len[id];
        m_v[f].pos  = 0;
`ifdef SOUND_VOICE_LOOP_EN
        m_v[f].loop = lp;
`else
        m_v[f].loop = 1'b0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_active();
        logic [31:0] m;
        m = '0;
        for (int v = 0; v < N_VOICES; v++) m[v] = m_v[v].act;
        return m;
    endfunction

    task automatic tbl_write(input int idx, input int addr, input int len);
        @(negedge clk);
        tbl_we = 1'b1; tbl_idx = 5'(idx); tbl_addr = 20'(addr); tbl_len = 20'(len);
        @(negedge clk);
        tbl_we = 1'b0;
        m_tbl_addr[idx] = addr & AMASK;
        m_tbl_len[idx]  = len & AMASK;
    endtask

    task automatic wait_sample();
        int n;
        n = 0;
        while (exp_samples.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sample_timeout", 32'(exp_samples.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic trigger(input int id, input bit lp);
        bit exp_drop;
        @(negedge clk);
        trig = 1'b1; trig_id = 5'(id); trig_loop = lp;
        exp_drop = model_trig(id, lp);
        @(negedge clk);
        trig = 1'b0; trig_loop = 1'b0;
        check("trig_drop", 32'(trig_drop), 32'(exp_drop));
        @(negedge clk);
        check("active_after_trig", 32'(active), model_active());
    endtask

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        model_tick(-1);
        @(negedge clk);
        sample_tick = 1'b0;
        wait_sample();
        check("active_after_tick", 32'(active), model_active());
    endtask

    task automatic trig_tick(input int id);
        bit exp_drop;
        @(negedge clk);
        trig = 1'b1; trig_id = 5'(id); sample_tick = 1'b1;
        exp_drop = model_trig(id, 1'b0);
        model_tick(-1);
        @(negedge clk);
        trig = 1'b0; sample_tick = 1'b0;
        check("trig_tick_drop", 32'(trig_drop), 32'(exp_drop));
        wait_sample();
    endtask

    task automatic stop();
        @(negedge clk);
        stop_all = 1'b1;
        for (int v = 0; v < N_VOICES; v++) m_v[v].act = 1'b0;
        @(negedge clk);
        stop_all = 1'b0;
        @(negedge clk);
        check("active_after_stop", 32'(active), 32'd0);
    endtask

    // Sample monitor: pops the scoreboard whenever the mixer emits.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && sample_valid) begin
                if (exp_samples.size() == 0) begin
                    check("unexpected_sample", 32'(sample), 32'hDEAD);
                end else begin
                    e = exp_samples.pop_front();
                    check("sample", 32'(sample), 32'(e));
                end
            end
        end
    end

    // SRAM responder: checks each new request address, acks after ack_delay cycles.
    initial begin
        bit in_req;
        int wcnt;
        int d;
        in_req = 1'b0;
        wcnt = 0;
        rd_if.i_rd_ack  = 1'b0;
        rd_if.i_rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_if.i_rd_ack) begin
                rd_if.i_rd_ack = 1'b0;
            end else if (!rst && rd_if.o_rd_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt   = 0;
                    if (exp_addrs.size() == 0) check("unexpected_read", 32'(rd_if.o_rd_addr), 32'hFFFF_FFFF);
                    else check("rd_addr", 32'(rd_if.o_rd_addr), 32'(exp_addrs.pop_front()));
                end
                if (wcnt >= ack_delay) begin
                    d = sram_val(int'(rd_if.o_rd_addr));
                    rd_if.i_rd_data = 16'(d);
                    rd_if.i_rd_ack  = 1'b1;
                    in_req = 1'b0;
                    ack_count++;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        int base_acks;
        int n;
        int r;
        rst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_len = '0;
        trig = 1'b0; trig_id = '0; trig_loop = 1'b0; stop_all = 1'b0; sample_tick = 1'b0;
        for (int i = 0; i < N_SOUNDS; i++) begin m_tbl_addr[i] = 0; m_tbl_len[i] = 0; end
        for (int v = 0; v < N_VOICES; v++) m_v[v] = '{1'b0, 0, 0, 0, 1'b0};
        repeat (3) @(negedge clk);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_rd_req", 32'(rd_if.o_rd_req), 32'd0);
        check("rst_rd_addr", 32'(rd_if.o_rd_addr), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_drop", 32'(trig_drop), 32'd0);
        check("rst_ready", 32'(trig_ready), 32'd1);
        rst = 1'b0;

        // Basic one-shot playback: 100,200,300,400 then silence.
        for (int i = 0; i < 4; i++) mem[160000 + i] = 16'(100 * (i + 1));
        tbl_write(3, 160000, 4);
        trigger(3, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        // Voice allocation and drop conditions.
        for (int i = 20; i < 25; i++) tbl_write(i, 32'h10000 * (i - 19), 1000);
        tbl_write(19, 32'h5000, 0);
        for (int i = 20; i < 25; i++) trigger(i, 1'b0);
        check("all_voices_busy", 32'(active), 32'hF);
        stop();
        trigger(19, 1'b0);

        // Saturation in both directions.
        mem[32'h1000] = 16'h7000; mem[32'h1001] = 16'h7000; mem[32'h2000] = 16'h8000;
        tbl_write(6, 32'h1000, 2);
        tbl_write(7, 32'h2000, 1);
        trigger(6, 1'b0);
        trigger(6, 1'b0);
        tick();
        check("sat_pos", 32'(sample), 32'h7FFF);
        tick();
        trigger(7, 1'b0);
        trigger(7, 1'b0);
        tick();
        check("sat_neg", 32'(sample), 32'h8000);

        // Trigger and tick together: the new voice is heard immediately.
        trig_tick(3);
        stop();

        // Tick during a stalled fetch sets the sticky overrun flag.
        tbl_write(8, 32'h3000, 5);
        trigger(8, 1'b0);
        ack_delay = 50;
        @(negedge clk); sample_tick = 1'b1; model_tick(-1);
        @(negedge clk); sample_tick = 1'b0;
        repeat (10) @(negedge clk);
        check("ready_in_fetch", 32'(trig_ready), 32'd0);
        sample_tick = 1'b1;
        @(negedge clk); sample_tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_sample();
        check("overrun_sticky", 32'(overrun), 32'd1);
        ack_delay = 0;
        tick();
        stop();

        // Stop-all while the second voice's read is outstanding.
        tbl_write(9, 32'h4000, 5);
        trigger(8, 1'b0);
        trigger(9, 1'b0);
        ack_delay = 5;
        base_acks = ack_count;
        @(negedge clk); sample_tick = 1'b1; model_tick(1);
        @(negedge clk); sample_tick = 1'b0;
        n = 0;
        while (!(ack_count > base_acks && rd_if.o_rd_req && !rd_if.i_rd_ack) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stop_wait_timeout", 32'(n < 500), 32'd1);
        stop();
        wait_sample();
        ack_delay = 0;

        // Short entry across the top of the address space, optionally looping.
        tbl_write(10, 32'hFFFFE, 3);
        trigger(10, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        stop();

        // Randomized mix of table writes, triggers, ticks and stops.
        for (int it = 0; it < 60; it++) begin
            ack_delay = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 2) tbl_write($urandom_range(11, 18), $urandom_range(0, 32'hFFFFF), $urandom_range(0, 5));
            else if (r < 5) trigger($urandom_range(11, 18), 1'($urandom_range(0, 1)));
            else if (r < 8) tick();
            else if (r == 8) trig_tick($urandom_range(11, 18));
            else stop();
        end

        repeat (5) @(negedge clk);
        check("addr_drain", 32'(exp_addrs.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_voice_mixer.md
Name: sound_voice_mixer

Overview:
- Parametrised successor to the fixed sound-effect address/length table.
- Holds a runtime-programmable sound table (base address, length per sound ID) and plays up to N_VOICES effects concurrently.
- Fetches one 16-bit signed sample per active voice per sample tick from the shared SRAM read port, then mixes with saturation.
- Sits between the game-logic trigger source and the audio DAC serializer.

Parameters:
N_SOUNDS, 25, number of sound-table entries.
N_VOICES, 4, concurrent playback voices.
ADDR_W, 20, SRAM word address / length width.
SAMPLE_W, 16, signed sample width.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_tbl_we  in  1  table write strobe
i_tbl_idx  in  clog2(N_SOUNDS)  table entry written
i_tbl_addr  in  ADDR_W  base address written
i_tbl_len  in  ADDR_W  length in samples written; 0 = empty entry
i_trig  in  1  start-sound request
i_trig_id  in  clog2(N_SOUNDS)  sound ID to start
i_trig_loop  in  1  loop request (see Optional Feature)
i_stop_all  in  1  deactivate all voices
o_trig_ready  out  1  high when a trigger is accepted this cycle
o_trig_drop  out  1  1-cycle pulse: trigger accepted but discarded
i_sample_tick  in  1  1-cycle pulse at the audio sample rate
o_rd_req  out  1  SRAM read request
o_rd_addr  out  ADDR_W  SRAM read address
i_rd_ack  in  1  read acknowledge; i_rd_data is valid in the same cycle
i_rd_data  in  SAMPLE_W  SRAM sample data
o_sample  out  SAMPLE_W  mixed sample, signed, saturated
o_sample_valid  out  1  1-cycle pulse when o_sample updates
o_active  out  N_VOICES  per-voice busy flags
o_overrun  out  1  sticky flag; set when a tick arrives outside IDLE

Behaviour:
- Reset: all table entries 0, all voices inactive, FSM in IDLE. Outputs: o_sample=0, o_sample_valid=0, o_rd_req=0, o_rd_addr=0, o_active=0, o_overrun=0, o_trig_drop=0.
- Table write: takes effect the next cycle. Playing voices keep their latched base and length.
- FSM states: IDLE, FETCH, MIX.
- IDLE:
  - o_trig_ready=1.
  - On i_trig, allocate the lowest-index inactive voice: latch base, len, loop flag, pos=0.
  - If no voice is free, or the entry length is 0: pulse o_trig_drop the next cycle and change no state.
  - On i_sample_tick: clear the accumulator, set v=0, go to FETCH.
  - Trigger and tick in the same cycle: the trigger is applied first, and the new voice contributes to this sample.
- FETCH (v = 0..N_VOICES-1):
  - Inactive voice: skip it in 1 cycle.
  - Active voice: hold o_rd_req=1 and o_rd_addr=base+pos (mod 2^ADDR_W) until i_rd_ack.
  - On ack: acc += sign-extended i_rd_data. If pos==len-1, deactivate the voice (or wrap pos to 0 if looping); otherwise pos++.
  - o_rd_req drops the cycle after ack.
  - After v = N_VOICES-1, go to MIX.
- MIX:
  - Accumulator width is SAMPLE_W+clog2(N_VOICES).
  - Saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], register into o_sample, pulse o_sample_valid for 1 cycle.
  - Return to IDLE.
- o_overrun: set when i_sample_tick is seen in FETCH or MIX. That tick is dropped. Cleared only by reset.
- i_stop_all: clears all voices in any state.
  - In FETCH, an outstanding request completes normally, but its data is not accumulated and pos is not updated.
  - The current sample still emits, using the samples already accumulated.
- o_active reflects the voice registers with 1-cycle latency from their update.
- Reset asserted mid-FETCH: o_rd_req drops the next cycle. Any ack already in flight is ignored.

Optional Feature:
- Macro: SOUND_VOICE_LOOP_EN.
- Defined: i_trig_loop is latched per voice. A looping voice wraps pos from len-1 to 0 and plays until i_stop_all.
- Undefined: i_trig_loop is ignored and every voice is one-shot. The port remains present.

Test Plan:
- Program entry 3 = (addr 160000, len 4); trigger ID 3; give 5 ticks, SRAM returning 100,200,300,400 -> o_rd_addr 160000..160003 then no request; o_sample = 100,200,300,400,0; o_active[0] falls after the 4th fetch.
- Trigger 5 sounds with N_VOICES=4 -> voices 0-3 active; 5th trigger gives an o_trig_drop pulse; trigger of a len-0 entry also drops.
- Two voices returning 0x7000 each -> o_sample=0x7FFF; two voices returning 0x8000 -> o_sample=0x8000.
- Tick while i_rd_ack is held low for 50 cycles in FETCH -> o_overrun=1 and stays 1; next sample is still emitted correctly.
- i_stop_all mid-FETCH with two active voices -> o_active=0 next cycle; emitted sample includes only voices already accumulated.
- With SOUND_VOICE_LOOP_EN and len 3 looping -> addresses base, base+1, base+2, base, base+1...; without the macro -> stops after 3.
